// File: rtl/match_controller.sv
// Match-level sequencer for the pong core: idle -> serve -> play -> point -> over.
// Optional freeze support is compiled in when MATCH_PAUSE_EN is defined.
module match_controller #(
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned SERVE_DELAY = 50,
  parameter int unsigned OVER_HOLD   = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pointLeft,
  input  logic       pointRight,
  input  logic [3:0] leftScore,
  input  logic [3:0] rightScore,
  input  logic       pause,
  output logic       gameResetN,
  output logic       scoreResetN,
  output logic       serveLeft,
  output logic [2:0] matchState,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StServe = 3'd1,
    StPlay  = 3'd2,
    StPoint = 3'd3,
    StOver  = 3'd4
  } state_e;

  localparam logic [3:0]  WinScore  = 4'(WIN_SCORE);
  localparam logic [15:0] ServeLast = 16'(SERVE_DELAY - 1);
  localparam logic [15:0] OverHold  = 16'(OVER_HOLD);

  state_e      state_q;
  logic        start_q;
  logic [15:0] cnt_q;

  logic start_edge;
  logic hold;
  logic win_left;
  logic win_right;

  assign start_edge = start & ~start_q;
  assign win_left   = (leftScore >= WinScore);
  assign win_right  = (rightScore >= WinScore);
  assign matchState = state_q;

`ifdef MATCH_PAUSE_EN
  assign hold = pause;
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign hold         = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      start_q     <= 1'b0;
      cnt_q       <= '0;
      gameResetN  <= 1'b0;
      scoreResetN <= 1'b1;
      serveLeft   <= 1'b0;
      winner      <= 2'b00;
    end else begin
      start_q     <= start;
      // Scoreboard clear is a single-cycle strobe raised only on match start.
      scoreResetN <= 1'b1;
      case (state_q)
        StIdle: begin
          gameResetN <= 1'b0;
          cnt_q      <= '0;
          if (start_edge) begin
            state_q     <= StServe;
            scoreResetN <= 1'b0;
            winner      <= 2'b00;
            serveLeft   <= 1'b0;
          end
        end

        StServe: begin
          gameResetN <= 1'b0;
          if (!hold) begin
            if (cnt_q == ServeLast) begin
              state_q    <= StPlay;
              cnt_q      <= '0;
              gameResetN <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
        end

        StPlay: begin
          gameResetN <= ~hold;
          if (!hold && (pointLeft || pointRight)) begin
            state_q    <= StPoint;
            cnt_q      <= '0;
            gameResetN <= 1'b0;
            // The side that lost the rally serves; a tie leaves the server alone.
            if (pointLeft && !pointRight) begin
              serveLeft <= 1'b1;
            end else if (pointRight && !pointLeft) begin
              serveLeft <= 1'b0;
            end
          end
        end

        StPoint: begin
          gameResetN <= 1'b0;
          // Second cycle: the scoreboard has registered the point by now.
          if (cnt_q == 16'd1) begin
            cnt_q <= '0;
            if (win_left || win_right) begin
              state_q <= StOver;
              winner  <= {win_right, win_left};
            end else begin
              state_q <= StServe;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        StOver: begin
          gameResetN <= 1'b0;
          if (cnt_q == OverHold) begin
            if (start_edge) begin
              state_q     <= StServe;
              cnt_q       <= '0;
              scoreResetN <= 1'b0;
              winner      <= 2'b00;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        default: begin
          state_q    <= StIdle;
          cnt_q      <= '0;
          gameResetN <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_match_controller.sv
// Self-checking bench for match_controller; the bench plays the scoreboard role and
// predicts each transaction (serve length, point outcome, over hold) from the match rules.
module tb_match_controller;

  localparam int unsigned WinScore   = 7;
  localparam int unsigned ServeDelay = 30;
  localparam int unsigned OverHold   = 40;
`ifdef MATCH_PAUSE_EN
  localparam bit PauseEn = 1'b1;
`else
  localparam bit PauseEn = 1'b0;
`endif

  localparam logic [2:0] SIdle  = 3'd0;
  localparam logic [2:0] SServe = 3'd1;
  localparam logic [2:0] SPlay  = 3'd2;
  localparam logic [2:0] SPoint = 3'd3;
  localparam logic [2:0] SOver  = 3'd4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       point_left;
  logic       point_right;
  logic [3:0] left_score;
  logic [3:0] right_score;
  logic       pause;
  logic       game_reset_n;
  logic       score_reset_n;
  logic       serve_left;
  logic [2:0] match_state;
  logic [1:0] winner;

  int checks = 0;
  int errors = 0;

  // Expected-state model: scores, current server and the latched winner.
  int unsigned l_pts = 0;
  int unsigned r_pts = 0;
  logic        exp_serve_left = 1'b0;
  logic [1:0]  exp_winner = 2'b00;

  wire [7:0] obs = {match_state, game_reset_n, score_reset_n, serve_left, winner};

  match_controller #(
    .WIN_SCORE  (WinScore),
    .SERVE_DELAY(ServeDelay),
    .OVER_HOLD  (OverHold)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pointLeft  (point_left),
    .pointRight (point_right),
    .leftScore  (left_score),
    .rightScore (right_score),
    .pause      (pause),
    .gameResetN (game_reset_n),
    .scoreResetN(score_reset_n),
    .serveLeft  (serve_left),
    .matchState (match_state),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_scores();
    left_score  = l_pts[3:0];
    right_score = r_pts[3:0];
  endtask

  task automatic start_match(input bit from_idle, input string tag);
    logic [7:0] exp;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (from_idle) exp_serve_left = 1'b0;
    exp_winner = 2'b00;
    exp = {SServe, 1'b0, 1'b0, exp_serve_left, 2'b00};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b (state|gameResetN|scoreResetN|serveLeft|winner)",
               tag, obs, exp);
    end
    l_pts = 0;
    r_pts = 0;
    drive_scores();
  endtask

  // Starts on the first SERVE cycle; returns on the first PLAY cycle.
  task automatic serve_to_play(input int pause_at, input int pause_len, input bit noise);
    logic [7:0] exp;
    int total;
    total = ServeDelay + (PauseEn ? pause_len : 0);
    for (int k = 0; k < total; k++) begin
      pause = (k >= pause_at) && (k < pause_at + pause_len);
      if (noise) begin
        point_left  = 1'($urandom_range(0, 1));
        point_right = 1'($urandom_range(0, 1));
        start       = 1'($urandom_range(0, 1));
      end
      tick();
      pause = 1'b0;
      point_left = 1'b0;
      point_right = 1'b0;
      start = 1'b0;
      if (k + 1 < total) exp = {SServe, 1'b0, 1'b1, exp_serve_left, 2'b00};
      else exp = {SPlay, 1'b1, 1'b1, exp_serve_left, 2'b00};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL serve_cycle_%0d: got %b want %b (state|gameResetN|scoreResetN|serveLeft|winner)",
                 k + 1, obs, exp);
      end
    end
  endtask

  task automatic play_wait(input int n);
    logic [7:0] exp;
    for (int k = 0; k < n; k++) begin
      start = 1'($urandom_range(0, 1));
      tick();
      start = 1'b0;
      exp = {SPlay, 1'b1, 1'b1, exp_serve_left, 2'b00};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL play_hold: got %b want %b (state|gameResetN|scoreResetN|serveLeft|winner)",
                 obs, exp);
      end
    end
  endtask

  // res: 0 back to SERVE, 1 match over, 2 pulse swallowed by pause (still PLAY).
  task automatic do_point(input bit pl, input bit pr, input bit ps, input string tag,
                          output int res);
    logic [7:0] exp;
    bit lw;
    bit rw;
    point_left = pl;
    point_right = pr;
    pause = ps;
    tick();
    point_left = 1'b0;
    point_right = 1'b0;
    pause = 1'b0;
    if (ps && PauseEn) begin
      exp = {SPlay, 1'b0, 1'b1, exp_serve_left, 2'b00};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s_paused: got %b want %b", tag, obs, exp);
      end
      tick();
      exp = {SPlay, 1'b1, 1'b1, exp_serve_left, 2'b00};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s_resume: got %b want %b", tag, obs, exp);
      end
      res = 2;
    end else begin
      if (pl) l_pts = (l_pts < 15) ? l_pts + 1 : 15;
      if (pr) r_pts = (r_pts < 15) ? r_pts + 1 : 15;
      drive_scores();
      if (pl && !pr) exp_serve_left = 1'b1;
      else if (pr && !pl) exp_serve_left = 1'b0;
      for (int c = 0; c < 2; c++) begin
        exp = {SPoint, 1'b0, 1'b1, exp_serve_left, 2'b00};
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL %s_point%0d: got %b want %b (state|gameResetN|scoreResetN|serveLeft|winner)",
                   tag, c, obs, exp);
        end
        pause = 1'($urandom_range(0, 1));
        tick();
        pause = 1'b0;
      end
      lw = (l_pts >= WinScore);
      rw = (r_pts >= WinScore);
      if (lw || rw) begin
        exp_winner = {rw, lw};
        exp = {SOver, 1'b0, 1'b1, exp_serve_left, exp_winner};
        res = 1;
      end else begin
        exp = {SServe, 1'b0, 1'b1, exp_serve_left, 2'b00};
        res = 0;
      end
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s_outcome: got %b want %b (state|gameResetN|scoreResetN|serveLeft|winner)",
                 tag, obs, exp);
      end
    end
  endtask

  // Starts on the first OVER cycle; early start edges must be ignored.
  task automatic over_restart(input string tag);
    logic [7:0] exp;
    int early;
    early = int'($urandom_range(0, OverHold - 3));
    for (int k = 0; k < OverHold + 1; k++) begin
      start = (k == early) || (k == OverHold - 1);
      pause = 1'($urandom_range(0, 1));
      tick();
      start = 1'b0;
      pause = 1'b0;
      exp = {SOver, 1'b0, 1'b1, exp_serve_left, exp_winner};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s_hold%0d: got %b want %b (state|gameResetN|scoreResetN|serveLeft|winner)",
                 tag, k, obs, exp);
      end
    end
    repeat ($urandom_range(0, 3)) tick();
    start_match(1'b0, {tag, "_restart"});
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    exp = {SIdle, 1'b0, 1'b1, 1'b0, 2'b00};
    #2 reset = 1'b0;
    #2;
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset_values: got %b want %b", obs, exp);
    end
    tick();
    tick();
    reset = 1'b1;
    point_left = 1'b1;
    pause = 1'b1;
    repeat (3) tick();
    point_left = 1'b0;
    pause = 1'b0;
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL idle_no_start: got %b want %b", obs, exp);
    end
  endtask

  task automatic test_start_serve();
    start_match(1'b1, "start_edge");
    serve_to_play(0, 0, 1'b0);
  endtask

  task automatic test_point_right();
    int res;
    l_pts = 2;
    r_pts = 2;
    drive_scores();
    play_wait(3);
    do_point(1'b0, 1'b1, 1'b0, "point_right", res);
    serve_to_play(0, 0, 1'b1);
  endtask

  task automatic test_win_left();
    int res;
    l_pts = 6;
    r_pts = 3;
    drive_scores();
    play_wait(2);
    do_point(1'b1, 1'b0, 1'b0, "win_left", res);
    over_restart("win_left");
    serve_to_play(0, 0, 1'b0);
  endtask

  task automatic test_both_points();
    int res;
    l_pts = 6;
    r_pts = 6;
    drive_scores();
    do_point(1'b1, 1'b1, 1'b0, "both", res);
    over_restart("both");
    serve_to_play(0, 0, 1'b0);
  endtask

  task automatic test_pause();
    int res;
    do_point(1'b1, 1'b0, 1'b1, "pause_point", res);
    if (res == 0) serve_to_play(0, 0, 1'b0);
    do_point(1'b0, 1'b1, 1'b0, "pre_pause", res);
    serve_to_play(10, 10, 1'b0);
  endtask

  task automatic test_mid_reset();
    logic [7:0] exp;
    int res;
    do_point(1'b1, 1'b0, 1'b0, "pre_reset", res);
    repeat (20) tick();
    exp = {SServe, 1'b0, 1'b1, exp_serve_left, 2'b00};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL serve_count20: got %b want %b", obs, exp);
    end
    #2 reset = 1'b0;
    #1;
    exp = {SIdle, 1'b0, 1'b1, 1'b0, 2'b00};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL mid_reset_async: got %b want %b", obs, exp);
    end
    tick();
    reset = 1'b1;
    exp_serve_left = 1'b0;
    l_pts = 0;
    r_pts = 0;
    drive_scores();
    point_right = 1'b1;
    tick();
    point_right = 1'b0;
    repeat (4) tick();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL idle_after_reset: got %b want %b", obs, exp);
    end
    start_match(1'b1, "start_after_reset");
    serve_to_play(int'($urandom_range(0, ServeDelay - 1)), int'($urandom_range(1, 6)), 1'b1);
  endtask

  task automatic test_random_matches();
    int res;
    int sel;
    bit pl;
    bit pr;
    for (int m = 0; m < 3; m++) begin
      for (int it = 0; it < 80; it++) begin
        play_wait(int'($urandom_range(0, 4)));
        sel = int'($urandom_range(0, 7));
        pl = (sel <= 3);
        pr = (sel == 0) || (sel >= 4);
        do_point(pl, pr, ($urandom_range(0, 3) == 0), "rand", res);
        if (res == 1) begin
          over_restart("rand_over");
          serve_to_play(0, 0, 1'b1);
          break;
        end else if (res == 0) begin
          serve_to_play(int'($urandom_range(0, ServeDelay - 1)), int'($urandom_range(0, 5)),
                        1'b1);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    point_left = 1'b0;
    point_right = 1'b0;
    pause = 1'b0;
    left_score = 4'd0;
    right_score = 4'd0;
    test_reset();
    test_start_serve();
    test_point_right();
    test_win_left();
    test_both_points();
    test_pause();
    test_mid_reset();
    test_random_matches();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/match_controller.md
# match_controller

Match-level sequencer for the pong game core. Owns the flow idle → serve → play → point → game-over and drives the hold/release of the ball and paddles, the scoreboard clear and the serve direction. Reads the 4-bit scores and point pulses from the game datapath and stops the match when a side reaches the target score. Sits between the board inputs and the game core, replacing the free-running release-after-reset behaviour.

## Interface
Parameters:
- WIN_SCORE, 7: score (1–15) that ends the match.
- SERVE_DELAY, 50: cycles the ball and paddles are held in SERVE before release (≥1).
- OVER_HOLD, 100: minimum cycles in OVER before a new start is accepted (≥1).

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-low; clears all state.
- start  in  1  level from button; rising edge detected internally.
- pointLeft  in  1  one-cycle pulse: left side won the rally.
- pointRight  in  1  one-cycle pulse: right side won the rally.
- leftScore  in  4  scoreboard value, updated one cycle after a point pulse.
- rightScore  in  4  as above.
- pause  in  1  freeze request (used only with MATCH_PAUSE_EN).
- gameResetN  out  1  low holds ball/paddles in reset; high only in PLAY.
- scoreResetN  out  1  low for exactly one cycle to clear the scoreboard.
- serveLeft  out  1  1 = ball launches toward the left side.
- matchState  out  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.
- winner  out  2  00 none, 01 left, 10 right, 11 simultaneous.

## Operation
- Start edge: startEdge = start & ~start_q; start_q registered, reset to 0.
- IDLE: gameResetN=0. startEdge → SERVE; scoreResetN=0 that next cycle; winner←00; serveLeft←0.
- SERVE: 16-bit counter runs from 0; at count == SERVE_DELAY-1 → PLAY. Counter cleared on every state entry.
- PLAY: gameResetN=1. pointLeft only → POINT, serveLeft←1 (loser serves). pointRight only → POINT, serveLeft←0. Both in the same cycle → POINT, serveLeft unchanged.
- POINT: gameResetN=0; occupies exactly 2 cycles so the registered score is settled; on the 2nd cycle compare: leftScore≥WIN_SCORE and rightScore≥WIN_SCORE → OVER, winner=11; left only → OVER, 01; right only → OVER, 10; else → SERVE.
- OVER: gameResetN=0; winner held. Counter saturates at OVER_HOLD; startEdge ignored until count == OVER_HOLD, then startEdge → SERVE with scoreResetN=0 one cycle, winner←00.
- Point pulses outside PLAY are ignored. startEdge outside IDLE/OVER is ignored.
- Undefined matchState encodings → IDLE.

## Timing
- Reset values: matchState=IDLE, gameResetN=0, scoreResetN=1, serveLeft=0, winner=00, counter=0, start_q=0.
- All outputs registered; no combinational path input→output.
- start rising at cycle n → matchState=SERVE and scoreResetN=0 at n+1; scoreResetN=1 at n+2.
- SERVE entered at cycle m → PLAY and gameResetN=1 at m+SERVE_DELAY.
- Point pulse at cycle p → POINT at p+1, gameResetN=0 at p+1; next state (SERVE/OVER) at p+3.
- Reset asserted mid-match: immediate return to reset values regardless of state; scores are cleared by the scoreboard's own reset.

## Configuration
- MATCH_PAUSE_EN defined: in SERVE or PLAY, pause=1 freezes the counter and state and forces gameResetN=0 for the paused cycles; point pulses during pause are ignored; state resumes on the cycle after pause falls. Pause has no effect in IDLE, POINT, OVER.
- MATCH_PAUSE_EN undefined: pause input is ignored; no pause logic synthesised.

## Test plan
- Reset then start pulse (cycle 5) → SERVE at 6, scoreResetN low only at 6, PLAY and gameResetN=1 at 6+SERVE_DELAY.
- In PLAY, pointRight with scores 2/3 → POINT 2 cycles, serveLeft=0, back to SERVE, then PLAY after SERVE_DELAY.
- leftScore reaching 7 after pointLeft → OVER, winner=01; start before OVER_HOLD ignored; start after → SERVE, winner=00, scoreResetN pulse.
- pointLeft and pointRight same cycle, scores 7/7 → OVER, winner=11; serveLeft unchanged.
- Reset asserted mid-SERVE at count 20 → all outputs at reset values immediately; start edge required to leave IDLE.
- MATCH_PAUSE_EN: pause for 10 cycles in SERVE at count 10 → PLAY entry delayed by exactly 10 cycles; pointLeft during pause in PLAY ignored.
